// File: rtl/risci_fetch_queue.sv
// risci_fetch_queue: instruction prefetch unit. Owns the fetch PC, keeps at most
// one read outstanding to instruction memory and buffers returned words with
// their PCs in a small FIFO whose head is offered to decode via valid/ready.
// A redirect flushes the FIFO and restarts fetch; a response still in flight
// at that moment is waited out in DISCARD and dropped.
module risci_fetch_queue #(
   parameter int VLEN  = 64,
   parameter int ILEN  = 32,
   parameter int DEPTH = 4,
   parameter logic [VLEN-1:0] RESET_PC = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         hlt,
   input  logic                         redirect,
   input  logic [VLEN-1:0]              redirect_pc,
   output logic                         mem_req,
   output logic [VLEN-1:0]              mem_addr,
   input  logic                         mem_ack,
   input  logic [ILEN-1:0]              mem_data,
   output logic                         out_valid,
   output logic [ILEN-1:0]              out_instr,
   output logic [VLEN-1:0]              out_pc,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

   state_t          state_reg, state_next;
   logic [VLEN-1:0] fetch_pc_reg, fetch_pc_next;
   logic [VLEN-1:0] addr_reg, addr_next;
   logic [PW-1:0]   head_reg, head_next;
   logic [PW-1:0]   tail_reg, tail_next;
   logic [CW-1:0]   count_reg, count_next;
   logic [CW-1:0]   count_ack;
   logic            enq;
   logic            deq;

   logic [ILEN-1:0] instr_mem [DEPTH];
   logic [VLEN-1:0] pc_mem    [DEPTH];

   assign mem_req   = (state_reg != IDLE);
   assign mem_addr  = addr_reg;
   assign count     = count_reg;
   assign out_valid = (count_reg != '0);
   assign out_instr = instr_mem[head_reg];
   assign out_pc    = pc_mem[head_reg];

   // Next-state, fetch PC, request address and FIFO pointer/occupancy update.
   always_comb begin
      state_next    = state_reg;
      fetch_pc_next = fetch_pc_reg;
      addr_next     = addr_reg;
      head_next     = head_reg;
      tail_next     = tail_reg;
      count_next    = count_reg;
      enq           = 1'b0;
      deq           = out_valid && out_ready;
      // occupancy right after an ack lands, used to decide on back-to-back issue
      count_ack     = count_reg + CW'(1) - CW'(deq);

      if (redirect) begin
         // flush wins over everything; low address bits are forced to word alignment
         fetch_pc_next = redirect_pc & ~VLEN'(3);
         head_next     = '0;
         tail_next     = '0;
         count_next    = '0;
         deq           = 1'b0;
         case (state_reg)
            REQ:     state_next = mem_ack ? IDLE : DISCARD;
            DISCARD: state_next = mem_ack ? IDLE : DISCARD;
            default: state_next = IDLE;
         endcase
      end else begin
         case (state_reg)
            IDLE: begin
               // a request is only issued when a FIFO slot is free for its data
               if (!hlt && (count_reg < DEPTH_C)) begin
                  state_next = REQ;
                  addr_next  = fetch_pc_reg;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  enq           = 1'b1;
                  fetch_pc_next = fetch_pc_reg + VLEN'(4);
                  if (!hlt && (count_ack < DEPTH_C)) begin
                     state_next = REQ;
                     addr_next  = fetch_pc_reg + VLEN'(4);
                  end else begin
                     state_next = IDLE;
                  end
               end
            end
            DISCARD: begin
               if (mem_ack) begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
         if (enq) begin
            tail_next = tail_reg + PW'(1);
         end
         if (deq) begin
            head_next = head_reg + PW'(1);
         end
         count_next = count_reg + CW'(enq) - CW'(deq);
      end
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         fetch_pc_reg <= RESET_PC;
         addr_reg     <= RESET_PC;
         head_reg     <= '0;
         tail_reg     <= '0;
         count_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         fetch_pc_reg <= fetch_pc_next;
         addr_reg     <= addr_next;
         head_reg     <= head_next;
         tail_reg     <= tail_next;
         count_reg    <= count_next;
      end
   end

   // FIFO storage: one slot per entry, written with {data, request address} on enqueue.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         // Capture the acknowledged word into this slot when the tail points here.
         always_ff @(posedge clk) begin
            if (enq && (tail_reg == PW'(gi))) begin
               instr_mem[gi] <= mem_data;
               pc_mem[gi]    <= addr_reg;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_risci_fetch_queue.sv
// tb_risci_fetch_queue: table-driven vectors, directed corner-case sequences and
// a randomized run checked against a queue-based reference model.
module tb_risci_fetch_queue;

   localparam int VLEN  = 64;
   localparam int ILEN  = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic            clk = 1'b0;
   logic            rst;
   logic            hlt;
   logic            redirect;
   logic [VLEN-1:0] redirect_pc;
   logic            mem_req;
   logic [VLEN-1:0] mem_addr;
   logic            mem_ack;
   logic [ILEN-1:0] mem_data;
   logic            out_valid;
   logic [ILEN-1:0] out_instr;
   logic [VLEN-1:0] out_pc;
   logic            out_ready;
   logic [CW-1:0]   count;

   int errors = 0;
   int checks = 0;
   bit auto_mem = 1'b0;

   risci_fetch_queue #(
      .VLEN(VLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(64'h0)
   ) dut (
      .clk(clk), .rst(rst), .hlt(hlt), .redirect(redirect), .redirect_pc(redirect_pc),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
      .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
      .out_ready(out_ready), .count(count)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [ILEN-1:0] instr;
      logic [VLEN-1:0] pc;
   } ent_t;

   ent_t            q[$];
   int              pend;     // 0: no request, 1: live request, 2: request whose data is dropped
   logic [VLEN-1:0] m_fpc;
   logic [VLEN-1:0] m_addr;

   task automatic model_reset();
      q.delete();
      pend   = 0;
      m_fpc  = '0;
      m_addr = '0;
   endtask

   task automatic model_update();
      bit   take;
      bit   issue;
      ent_t e;
      if (redirect) begin
         q.delete();
         m_fpc = {redirect_pc[VLEN-1:2], 2'b00};
         if (pend == 1) pend = mem_ack ? 0 : 2;
         else if (pend == 2 && mem_ack) pend = 0;
      end else begin
         take = out_ready && (q.size() > 0);
         if (pend == 0) begin
            issue = !hlt && (q.size() < DEPTH);
            if (take) void'(q.pop_front());
            if (issue) begin
               pend   = 1;
               m_addr = m_fpc;
            end
         end else if (pend == 1) begin
            if (take) void'(q.pop_front());
            if (mem_ack) begin
               e.instr = mem_data;
               e.pc    = m_addr;
               q.push_back(e);
               m_fpc = m_fpc + 64'd4;
               if (!hlt && (q.size() < DEPTH)) m_addr = m_fpc;
               else pend = 0;
            end
         end else begin
            if (take) void'(q.pop_front());
            if (mem_ack) pend = 0;
         end
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      chk("mdl.mem_req",   64'(mem_req),   64'(pend != 0));
      chk("mdl.mem_addr",  mem_addr,       m_addr);
      chk("mdl.count",     64'(count),     64'(q.size()));
      chk("mdl.out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
         chk("mdl.out_pc",    out_pc,          q[0].pc);
         chk("mdl.out_instr", 64'(out_instr),  64'(q[0].instr));
      end
   endtask

   // One clock: inputs set beforehand, model advanced at the edge, outputs checked at negedge.
   task automatic step();
      if (auto_mem) begin
         mem_ack  = 1'b1;
         mem_data = mem_addr[31:0];
      end
      if (out_valid && out_ready && !redirect)
         $display("deq  pc=%h instr=%h count=%0d", out_pc, out_instr, count);
      @(posedge clk);
      model_update();
      @(negedge clk);
      model_check();
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      hlt         = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      mem_ack     = 1'b0;
      mem_data    = '0;
      out_ready   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.mem_req",   64'(mem_req),   64'd0);
      chk("rst.mem_addr",  mem_addr,       64'd0);
      chk("rst.count",     64'(count),     64'd0);
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      rst = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit              new_reset;
      bit              hlt;
      bit              ready;
      bit              exp_req;
      logic [63:0]     exp_addr;
      bit              exp_valid;
      logic [63:0]     exp_pc;
      int              exp_count;
   } vec_t;

   vec_t vecs[13];

   initial begin
      // zero-wait memory, consumer always ready: one fetch per cycle
      vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 64'h0,  1'b0, 64'h0, 0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 64'h4,  1'b1, 64'h0, 1};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 64'h8,  1'b1, 64'h4, 1};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 64'hC,  1'b1, 64'h8, 1};
      // zero-wait memory, consumer stalled: fill to DEPTH, then one pop frees one slot
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h0,  1'b0, 64'h0, 0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 64'h4,  1'b1, 64'h0, 1};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 64'h8,  1'b1, 64'h0, 2};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 64'hC,  1'b1, 64'h0, 3};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 64'hC,  1'b1, 64'h0, 4};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 64'hC,  1'b1, 64'h0, 4};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 64'hC,  1'b1, 64'h4, 3};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 64'h10, 1'b1, 64'h4, 3};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 64'h10, 1'b1, 64'h4, 4};

      for (int i = 0; i < 13; i++) begin
         if (vecs[i].new_reset) begin
            auto_mem = 1'b1;
            do_reset();
         end
         hlt       = vecs[i].hlt;
         out_ready = vecs[i].ready;
         step();
         $display("vec %0d: mem_req=%b mem_addr=%h out_valid=%b out_pc=%h count=%0d",
                  i, mem_req, mem_addr, out_valid, out_pc, count);
         chk("vec.mem_req",   64'(mem_req),   64'(vecs[i].exp_req));
         chk("vec.mem_addr",  mem_addr,       vecs[i].exp_addr);
         chk("vec.out_valid", 64'(out_valid), 64'(vecs[i].exp_valid));
         chk("vec.count",     64'(count),     64'(vecs[i].exp_count));
         if (vecs[i].exp_valid) begin
            chk("vec.out_pc",    out_pc,         vecs[i].exp_pc);
            chk("vec.out_instr", 64'(out_instr), {32'h0, vecs[i].exp_pc[31:0]});
         end
      end

      // ---- redirect during a slow response: old address held, its data dropped ----
      auto_mem = 1'b0;
      do_reset();
      step();
      chk("slow.req", 64'(mem_req), 64'd1);
      step();
      redirect = 1'b1; redirect_pc = 64'h1002;
      step();
      redirect = 1'b0;
      chk("slow.hold_req",  64'(mem_req), 64'd1);
      chk("slow.hold_addr", mem_addr,     64'h0);
      step();
      chk("slow.hold_addr2", mem_addr,     64'h0);
      chk("slow.count",      64'(count),   64'd0);
      mem_ack = 1'b1; mem_data = 32'hDEADBEEF;
      step();
      mem_ack = 1'b0;
      chk("slow.idle_req",  64'(mem_req),   64'd0);
      chk("slow.dropped",   64'(out_valid), 64'd0);
      step();
      chk("slow.new_req",  64'(mem_req), 64'd1);
      chk("slow.new_addr", mem_addr,     64'h1000);
      mem_ack = 1'b1; mem_data = 32'h0000_1000;
      step();
      mem_ack = 1'b0;
      chk("slow.out_pc",    out_pc,         64'h1000);
      chk("slow.out_instr", 64'(out_instr), 64'h1000);
      $display("seq slow-redirect done");

      // ---- redirect together with ack and dequeue while two entries are held ----
      auto_mem = 1'b1;
      do_reset();
      step(); step(); step();
      chk("coinc.count2", 64'(count), 64'd2);
      redirect = 1'b1; redirect_pc = 64'h2000; out_ready = 1'b1;
      step();
      redirect = 1'b0; out_ready = 1'b0;
      chk("coinc.count0", 64'(count),     64'd0);
      chk("coinc.valid0", 64'(out_valid), 64'd0);
      chk("coinc.req0",   64'(mem_req),   64'd0);
      step();
      chk("coinc.addr", mem_addr,     64'h2000);
      step();
      chk("coinc.out_pc", out_pc,     64'h2000);
      chk("coinc.count1", 64'(count), 64'd1);
      $display("seq coincident-redirect done");

      // ---- hlt while a request is outstanding ----
      auto_mem = 1'b0;
      do_reset();
      step();
      hlt = 1'b1;
      step();
      chk("hlt.still_req", 64'(mem_req), 64'd1);
      mem_ack = 1'b1; mem_data = 32'h1111_1111;
      step();
      mem_ack = 1'b0;
      chk("hlt.count",     64'(count),     64'd1);
      chk("hlt.out_instr", 64'(out_instr), 64'h1111_1111);
      chk("hlt.req_off",   64'(mem_req),   64'd0);
      step(); step();
      chk("hlt.still_off", 64'(mem_req), 64'd0);
      hlt = 1'b0;
      step();
      chk("hlt.resume_req",  64'(mem_req), 64'd1);
      chk("hlt.resume_addr", mem_addr,     64'h4);
      $display("seq hlt done");

      // ---- PC wrap at the top of the address space, then async reset mid-request ----
      auto_mem = 1'b1;
      do_reset();
      out_ready = 1'b1; hlt = 1'b1;
      redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      redirect = 1'b0; hlt = 1'b0;
      chk("wrap.idle", 64'(mem_req), 64'd0);
      step();
      chk("wrap.addr_top", mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      step();
      chk("wrap.addr_zero", mem_addr, 64'h0);
      chk("wrap.out_pc",    out_pc,   64'hFFFF_FFFF_FFFF_FFFC);
      step();
      chk("wrap.out_pc0", out_pc, 64'h0);
      #2 rst = 1'b1;
      #1;
      chk("arst.mem_req",   64'(mem_req),   64'd0);
      chk("arst.count",     64'(count),     64'd0);
      chk("arst.out_valid", 64'(out_valid), 64'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      $display("seq wrap/async-reset done");

      // ---- randomized run against the reference model ----
      auto_mem = 1'b0;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         hlt         = ($urandom_range(0, 9) < 2);
         redirect    = ($urandom_range(0, 19) == 0);
         redirect_pc = {$urandom, $urandom};
         out_ready   = $urandom_range(0, 1);
         mem_ack     = ((i % 400) < 100) ? 1'b1 : ($urandom_range(0, 9) < 6);
         mem_data    = $urandom;
         step();
      end
      redirect = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/risci_fetch_queue.md
Name: risci_fetch_queue

Overview:
Instruction prefetch unit sitting directly upstream of the core's decode path. It owns the fetch PC, issues one-outstanding-request reads to instruction memory, and buffers returned instruction words with their PCs in a small FIFO. The FIFO head is presented to the core with a valid/ready handshake. A branch redirect from execute flushes the queue, discards any in-flight response and restarts fetch at the new PC.

Parameters:
VLEN, 64, address/PC width
ILEN, 32, instruction width
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 0, fetch PC after reset

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
hlt  input  1  inhibit issue of new memory requests
redirect  input  1  flush and restart fetch, one-cycle pulse
redirect_pc  input  VLEN  new fetch PC, sampled when redirect=1
mem_req  output  1  instruction read request
mem_addr  output  VLEN  request address, word aligned
mem_ack  input  1  request accepted; mem_data valid this cycle
mem_data  input  ILEN  returned instruction word
out_valid  output  1  FIFO head valid
out_instr  output  ILEN  FIFO head instruction
out_pc  output  VLEN  PC of FIFO head
out_ready  input  1  core consumes head this cycle
count  output  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (async, any time, incl. mid-request): state=IDLE, fetch_pc=RESET_PC, head/tail pointers=0, count=0, mem_req=0, mem_addr=RESET_PC, out_valid=0. Any in-flight request is abandoned; memory must tolerate req dropping.
- FSM states: IDLE, REQ, DISCARD. mem_req=1 in REQ and DISCARD, registered (no combinational path from inputs).
- IDLE -> REQ when !hlt && !redirect && count < DEPTH; mem_addr <= fetch_pc.
- REQ: mem_addr and mem_req held stable until mem_ack. On mem_ack (no redirect): write {mem_data, mem_addr} at tail, tail++, fetch_pc += 4; next state REQ with mem_addr=fetch_pc+4 if !hlt and post-edge count < DEPTH, else IDLE. Zero-wait memory gives 1 instruction/cycle.
- Slot reservation: a request is only issued when count < DEPTH; count cannot rise while in REQ except by that request's ack, so overflow is impossible. Dequeue in REQ is allowed.
- hlt: blocks only new issue; an outstanding REQ completes and its data is enqueued. Dequeue unaffected.
- Output: out_valid = (count != 0); out_instr/out_pc = head entry (registered storage, combinational read). Dequeue when out_valid && out_ready: head++. Simultaneous enqueue+dequeue: count unchanged. out_ready with out_valid=0 ignored.
- redirect (highest priority): count<=0, head<=tail<=0, fetch_pc <= {redirect_pc[VLEN-1:2], 2'b00}, out_valid=0 the next cycle. Same-cycle dequeue/enqueue are discarded.
  - In IDLE, or in REQ with mem_ack same cycle: data dropped, state IDLE.
  - In REQ without mem_ack: state DISCARD; mem_req/mem_addr held on old address until mem_ack, data dropped, then IDLE.
  - In DISCARD: new redirect updates fetch_pc only; stays DISCARD until ack.
- First new request after redirect is issued in the cycle after the FSM reaches IDLE (min 1 idle cycle).
- fetch_pc arithmetic modulo 2^VLEN (wraps 0xFFFF_FFFF_FFFF_FFFC -> 0). FIFO pointers wrap modulo DEPTH.
- mem_ack outside REQ/DISCARD is ignored.

Test Plan:
- Reset then zero-wait memory (mem_ack tied 1, mem_data=addr[31:0]), out_ready=1 -> mem_addr 0,4,8,... on consecutive cycles; out_valid first high 2 cycles after rst falls; out_pc/out_instr match 0,4,8.
- out_ready=0, zero-wait memory -> exactly 4 entries (PCs 0..C) enqueued, count=4, mem_req low; raise out_ready one cycle -> head advances to PC 4, one new request at 0x10 issued.
- mem_ack delayed 3 cycles, redirect to 0x1002 in 2nd wait cycle -> mem_addr held at old PC until ack, that data never appears on out_*, next request address 0x1000, count=0 throughout.
- redirect coincident with mem_ack and out_ready while count=2 -> count=0 next cycle, acked word dropped, next fetch at redirect target.
- hlt asserted while REQ outstanding -> acked word enqueued, no further mem_req until hlt deasserted; then fetch resumes at following PC.
- redirect_pc=0xFFFF_FFFF_FFFF_FFFC, zero-wait memory -> fetch addresses ...FFFC then 0x0; rst pulsed mid-REQ -> mem_req=0, count=0, out_valid=0 asynchronously.
